fmul_axis_slave: RTL and testbench

FMUL_AXIS_SLAVE -- requirements
Module: fmul_axis_slave

---
 rtl/fmul_pkg.sv | 28 ++
 rtl/fmul_round.sv | 51 +++++
 rtl/fmul_axis_slave.sv | 135 +++++++++++++
 tb/tb_fmul_axis_slave.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fmul_pkg.sv
// Shared constants, the packed single-precision view and operand classifiers
// for the streaming float multiplier.
package fmul_pkg;

  localparam logic [31:0] QNAN         = 32'h7FC0_0000;
  localparam int          FMUL_LATENCY = 3;
  localparam int          EXP_BIAS     = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  // Denormals have a zero exponent and are deliberately classified as zero.
  function automatic logic is_zero(input float_t f);
    return f.exp == 8'h00;
  endfunction

  function automatic logic is_inf(input float_t f);
    return (f.exp == 8'hFF) && (f.frac == 23'h0);
  endfunction

  function automatic logic is_nan(input float_t f);
    return (f.exp == 8'hFF) && (f.frac != 23'h0);
  endfunction

endpackage

// File: rtl/fmul_round.sv
// Normalises the 48-bit mantissa product, rounds to nearest-even and packs
// the result, flushing underflow to signed zero and overflow to infinity.
module fmul_round (
  input  logic               sign,
  input  logic signed [9:0]  exp_in,
  input  logic        [47:0] prod,
  output logic        [31:0] result
);

  logic        [22:0] frac;
  logic               guard;
  logic               sticky;
  logic        [23:0] mant;
  logic signed [10:0] exp_n;
  logic signed [10:0] exp_r;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    frac   = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    mant   = '0;
    exp_n  = '0;
    exp_r  = '0;
    result = '0;

    // Product of two normalised mantissas lies in [1,4); bit 47 marks [2,4).
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    exp_n = {exp_in[9], exp_in} + {10'd0, prod[47]};

    mant  = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    // A carry out of the fraction means it rounded up to the next power of two.
    exp_r = exp_n + {10'd0, mant[23]};

    if (exp_r < 11'sd1)
      result = {sign, 31'h0};
    else if (exp_r >= 11'sd255)
      result = {sign, 8'hFF, 23'h0};
    else
      result = {sign, exp_r[7:0], mant[22:0]};
  end

endmodule

// File: rtl/fmul_axis_slave.sv
// AXI-Stream single-precision multiplier: one-entry hold per input channel,
// issue register, then unpack, multiply and round stages into the output slot.
module fmul_axis_slave
  import fmul_pkg::*;
#(
  parameter int STALL_FREE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  output logic [31:0] m_axis_result_tdata,
  output logic        m_axis_result_tvalid,
  input  logic        m_axis_result_tready
);

  float_t             a_hold, b_hold;
  logic               a_full, b_full;
  logic               a_take, b_take;
  logic               en, fire;

  float_t             op_a, op_b;
  logic               op_valid;

  logic               s1_valid, s1_sign, s1_special;
  logic signed [9:0]  s1_exp;
  logic        [23:0] s1_ma, s1_mb;
  logic        [31:0] s1_special_val;

  logic               s2_valid, s2_sign, s2_special;
  logic signed [9:0]  s2_exp;
  logic        [47:0] s2_prod;
  logic        [31:0] s2_special_val;

  logic               op_sign, spec_hit;
  logic        [31:0] spec_val;
  logic        [31:0] round_result;
  logic        [31:0] s3_result;

  assign s_axis_a_tready = ~a_full;
  assign s_axis_b_tready = ~b_full;
  assign a_take          = s_axis_a_tvalid & ~a_full;
  assign b_take          = s_axis_b_tvalid & ~b_full;

  // The reserved STALL_FREE=0 setting only advances into an empty output slot.
  assign en   = ~m_axis_result_tvalid | (m_axis_result_tready & (STALL_FREE != 0));
  // Fire looks only at registered hold flags, never at the incoming tvalids.
  assign fire = a_full & b_full & en;

  // Control state and the output slot: everything here must clear on reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_full               <= 1'b0;
      b_full               <= 1'b0;
      op_valid             <= 1'b0;
      s1_valid             <= 1'b0;
      s2_valid             <= 1'b0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
    end else begin
      if (a_take)    a_full <= 1'b1;
      else if (fire) a_full <= 1'b0;
      if (b_take)    b_full <= 1'b1;
      else if (fire) b_full <= 1'b0;

      if (en) begin
        op_valid             <= fire;
        s1_valid             <= op_valid;
        s2_valid             <= s1_valid;
        m_axis_result_tvalid <= s2_valid;
        if (s2_valid) m_axis_result_tdata <= s3_result;
      end
    end
  end

  // S1 special-case detection on the issued operands.
  assign op_sign = op_a.sign ^ op_b.sign;

  always_comb begin
    spec_hit = 1'b0;
    spec_val = '0;
    if (is_nan(op_a) || is_nan(op_b) ||
        (is_inf(op_a) && is_zero(op_b)) || (is_zero(op_a) && is_inf(op_b))) begin
      spec_hit = 1'b1;
      spec_val = QNAN;
    end else if (is_inf(op_a) || is_inf(op_b)) begin
      spec_hit = 1'b1;
      spec_val = {op_sign, 8'hFF, 23'h0};
    end else if (is_zero(op_a) || is_zero(op_b)) begin
      spec_hit = 1'b1;
      spec_val = {op_sign, 31'h0};
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits above qualify every one of them.
  always_ff @(posedge clk) begin
    if (a_take) a_hold <= float_t'(s_axis_a_tdata);
    if (b_take) b_hold <= float_t'(s_axis_b_tdata);

    if (en) begin
      if (fire) begin
        op_a <= a_hold;
        op_b <= b_hold;
      end

      s1_sign        <= op_sign;
      s1_exp         <= 10'(op_a.exp) + 10'(op_b.exp) - 10'(EXP_BIAS);
      s1_ma          <= {1'b1, op_a.frac};
      s1_mb          <= {1'b1, op_b.frac};
      s1_special     <= spec_hit;
      s1_special_val <= spec_val;

      s2_sign        <= s1_sign;
      s2_exp         <= s1_exp;
      s2_prod        <= 48'(s1_ma) * 48'(s1_mb);
      s2_special     <= s1_special;
      s2_special_val <= s1_special_val;
    end
  end

  fmul_round u_round (
    .sign   (s2_sign),
    .exp_in (s2_exp),
    .prod   (s2_prod),
    .result (round_result)
  );

  assign s3_result = s2_special ? s2_special_val : round_result;

endmodule

// File: tb/tb_fmul_axis_slave.sv
// Directed bench for fmul_axis_slave: hand-computed products, latency,
// hold/backpressure behaviour and reset flush.
module tb_fmul_axis_slave;
  import fmul_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] res_q[$];
  bit          saw_full;

  fmul_axis_slave #(.STALL_FREE(1)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .s_axis_a_tdata       (a_data),
    .s_axis_a_tvalid      (a_valid),
    .s_axis_a_tready      (a_ready),
    .s_axis_b_tdata       (b_data),
    .s_axis_b_tvalid      (b_valid),
    .s_axis_b_tready      (b_ready),
    .m_axis_result_tdata  (m_data),
    .m_axis_result_tvalid (m_valid),
    .m_axis_result_tready (m_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer A and B on the same edge into an idle pipeline, then wait for the product.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    bit seen = 1'b0;
    check({tag, "_rdy"}, {30'd0, a_ready, b_ready}, 32'd3);
    a_data  = a;
    b_data  = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      tick();
      if (m_valid) begin
        seen = 1'b1;
        check({tag, "_lat"}, k, FMUL_LATENCY + 1);
        check(tag, m_data, exp);
      end
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  task automatic send_a(input logic [31:0] d);
    bit hs;
    a_data  = d;
    a_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      hs = a_ready;
      tick();
      if (hs) break;
    end
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d);
    bit hs;
    b_data  = d;
    b_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      hs = b_ready;
      tick();
      if (hs) break;
    end
    b_valid = 1'b0;
  endtask

  // Holds result_tready low for the first stall_cycles, records every product taken.
  task automatic consume(input int stall_cycles, input int want);
    logic [31:0] held    = '0;
    bit          stalled = 1'b0;
    for (int c = 0; c < 100 && res_q.size() < want; c++) begin
      m_ready = (c >= stall_cycles);
      if (m_valid && !m_ready) begin
        if (stalled) check("stall_hold_data", m_data, held);
        held    = m_data;
        stalled = 1'b1;
        if (!a_ready && !b_ready) saw_full = 1'b1;
      end
      if (m_valid && m_ready) res_q.push_back(m_data);
      tick();
    end
    m_ready = 1'b1;
  endtask

  logic [31:0] sa [4] = '{32'h3F80_0000, 32'h3FC0_0000, 32'hC040_0000, 32'h3F00_0000};
  logic [31:0] sb [4] = '{32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000, 32'h3E80_0000};
  logic [31:0] se [4] = '{32'h4000_0000, 32'h4010_0000, 32'hC110_0000, 32'h3E00_0000};

  initial begin
    rstn    = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = '0;
    b_data  = '0;
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_tready", {31'd0, a_ready}, 32'd1);
    check("rst_b_tready", {31'd0, b_ready}, 32'd1);
    check("rst_tvalid",   {31'd0, m_valid}, 32'd0);
    check("rst_tdata",    m_data,           32'd0);
    rstn = 1'b1;
    tick();

    // Basic products, specials and rounding boundaries.
    do_op("mul_1p5x2",     32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    do_op("inf_x_zero",    32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000);
    do_op("overflow",      32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
    do_op("underflow",     32'h0080_0000, 32'h3F00_0000, 32'h0000_0000);
    do_op("neg_m2x3",      32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000);
    do_op("nan_in",        32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000);
    do_op("inf_x_neg2",    32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000);
    do_op("denorm_zero",   32'h0040_0000, 32'h3F80_0000, 32'h0000_0000);
    do_op("neg_zero",      32'hBF80_0000, 32'h0000_0000, 32'h8000_0000);
    do_op("rne_tie_up",    32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002);
    do_op("rne_tie_even",  32'h3F80_0003, 32'h3FC0_0000, 32'h3FC0_0004);
    do_op("norm_shift",    32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE);
    do_op("max_finite",    32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF);

    // A alone at cycle 0, B joins at cycle 5.
    a_data  = 32'h40A0_0000;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k <= 5) check("split_a_tready_low", {31'd0, a_ready}, 32'd0);
      if (k == 6) check("split_a_tready_back", {31'd0, a_ready}, 32'd1);
      if (k >= 6) check("split_tvalid", {31'd0, m_valid}, {31'd0, k == 9});
      if (k == 9) check("split_data", m_data, 32'h4120_0000);
      if (k == 4) begin
        b_data  = 32'h4000_0000;
        b_valid = 1'b1;
      end
      if (k == 5) b_valid = 1'b0;
    end
    tick();

    // Four streamed pairs against six cycles of backpressure.
    saw_full = 1'b0;
    res_q.delete();
    fork
      for (int i = 0; i < 4; i++) send_a(sa[i]);
      for (int j = 0; j < 4; j++) send_b(sb[j]);
      consume(6, 4);
    join
    check("stream_count", res_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("stream_res%0d", i), (i < res_q.size()) ? res_q[i] : 32'hDEAD_DEAD, se[i]);
    check("stream_holds_full", {31'd0, saw_full}, 32'd1);
    repeat (3) tick();
    check("stream_no_extra", {31'd0, m_valid}, 32'd0);

    // Reset pulse one edge after a fire.
    a_data  = 32'h4040_0000;
    b_data  = 32'h4040_0000;
    a_valid = 1'b1;
    b_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("rst_flush_tvalid", {31'd0, m_valid}, 32'd0);
      tick();
    end
    check("rst_flush_a_tready", {31'd0, a_ready}, 32'd1);
    check("rst_flush_b_tready", {31'd0, b_ready}, 32'd1);
    do_op("post_reset", 32'h4040_0000, 32'h4040_0000, 32'h4110_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
